// File: rtl/edge_event_monitor.sv
// Multi-channel edge-event monitor with per-channel saturating counters,
// sticky/saturation flags and a count-down waiter that raises done after N events.
module edge_event_monitor #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       sig_in,
    input  logic [2*NCH-1:0]     mode,
    input  logic                 clear,
    input  logic                 arm,
    input  logic [NCH-1:0]       arm_mask,
    input  logic [CNT_W-1:0]     arm_target,
    output logic [NCH-1:0]       evt_pulse,
    output logic [NCH*CNT_W-1:0] evt_count,
    output logic [NCH-1:0]       evt_sticky,
    output logic [NCH-1:0]       cnt_sat,
    output logic                 busy,
    output logic                 done
);

    localparam int HW = $clog2(NCH + 1);
    localparam int CW = CNT_W + HW;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    logic [NCH-1:0]   prev;
    logic [NCH-1:0]   match;
    logic [CNT_W-1:0] cnt [NCH];

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic [NCH-1:0]   mask, mask_nxt;
    logic [HW-1:0]    hits;

    // Detection uses the current mode, so a mode change affects this cycle's edge.
    always_comb begin
        match = '0;
        for (int i = 0; i < NCH; i++) begin
            case (mode[2*i +: 2])
                2'b01:   match[i] = sig_in[i] & ~prev[i];
                2'b10:   match[i] = ~sig_in[i] & prev[i];
                2'b11:   match[i] = sig_in[i] ^ prev[i];
                default: match[i] = 1'b0;
            endcase
        end
    end

    // prev follows sig_in in reset too, so releasing reset never fakes an edge.
    always_ff @(posedge clk) begin
        prev <= sig_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_pulse <= '0;
        end else begin
            evt_pulse <= match;
        end
    end

    // clear takes priority over a coincident match; the pulse above still fires.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst || clear) begin
                cnt[i]        <= '0;
                evt_sticky[i] <= 1'b0;
                cnt_sat[i]    <= 1'b0;
            end else if (match[i]) begin
                evt_sticky[i] <= 1'b1;
                if (cnt[i] == CMAX) begin
                    cnt_sat[i] <= 1'b1;
                end else begin
                    cnt[i]     <= cnt[i] + 1'b1;
                    cnt_sat[i] <= (cnt[i] == CMAX - 1'b1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            evt_count[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    always_comb begin
        hits = '0;
        for (int i = 0; i < NCH; i++) begin
            hits = hits + HW'(match[i] & mask[i]);
        end
    end

    // Arm restarts from any state; matches on the arm cycle are not counted.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        mask_nxt      = mask;
        if (arm) begin
            mask_nxt      = arm_mask;
            remaining_nxt = arm_target;
            state_nxt     = (arm_target == '0) ? DONE : WAIT;
        end else if (state == WAIT) begin
            if (CW'(hits) >= CW'(remaining)) begin
                state_nxt     = DONE;
                remaining_nxt = '0;
            end else begin
                remaining_nxt = remaining - CNT_W'(hits);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            mask      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            mask      <= mask_nxt;
            busy      <= (state_nxt == WAIT);
            done      <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_edge_event_monitor.sv
// Randomized and directed bench for edge_event_monitor: two instances (CNT_W=8 and
// CNT_W=2) share stimulus and are compared every cycle against a behavioural model.
module tb_edge_event_monitor;

    logic        clk = 1'b0;
    logic        rst, clear, arm;
    logic [3:0]  sig_in, arm_mask;
    logic [7:0]  mode, arm_target;

    logic [3:0]  pulse_a, sticky_a, sat_a, pulse_b, sticky_b, sat_b;
    logic [31:0] count_a;
    logic [7:0]  count_b;
    logic        busy_a, done_a, busy_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, index 0 = CNT_W 8 instance, 1 = CNT_W 2 instance
    int m_prev [4];
    int m_pulse[4];
    int m_cnt  [2][4];
    int m_stk  [2][4];
    int m_state[2];
    int m_rem  [2];
    int m_mask [2];
    int cmax   [2] = '{255, 3};

    always #5 clk = ~clk;

    edge_event_monitor #(.NCH(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clear(clear),
        .arm(arm), .arm_mask(arm_mask), .arm_target(arm_target),
        .evt_pulse(pulse_a), .evt_count(count_a), .evt_sticky(sticky_a),
        .cnt_sat(sat_a), .busy(busy_a), .done(done_a)
    );

    edge_event_monitor #(.NCH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .mode(mode), .clear(clear),
        .arm(arm), .arm_mask(arm_mask), .arm_target(arm_target[1:0]),
        .evt_pulse(pulse_b), .evt_count(count_b), .evt_sticky(sticky_b),
        .cnt_sat(sat_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit mat[4];
        int md, hits, tgt;
        bit rise, fall;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_prev[i]  = int'(sig_in[i]);
                m_pulse[i] = 0;
                for (int k = 0; k < 2; k++) begin
                    m_cnt[k][i] = 0;
                    m_stk[k][i] = 0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                m_state[k] = 0;
                m_rem[k]   = 0;
                m_mask[k]  = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                md     = int'(mode[2*i +: 2]);
                rise   = (sig_in[i] == 1'b1) && (m_prev[i] == 0);
                fall   = (sig_in[i] == 1'b0) && (m_prev[i] == 1);
                mat[i] = (md == 1 && rise) || (md == 2 && fall) || (md == 3 && (rise || fall));
                m_pulse[i] = int'(mat[i]);
            end
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) begin
                    if (clear) begin
                        m_cnt[k][i] = 0;
                        m_stk[k][i] = 0;
                    end else if (mat[i]) begin
                        m_cnt[k][i] = (m_cnt[k][i] + 1 > cmax[k]) ? cmax[k] : m_cnt[k][i] + 1;
                        m_stk[k][i] = 1;
                    end
                end
                if (arm) begin
                    tgt        = int'(arm_target) % (cmax[k] + 1);
                    m_mask[k]  = int'(arm_mask);
                    m_rem[k]   = tgt;
                    m_state[k] = (tgt == 0) ? 2 : 1;
                end else if (m_state[k] == 1) begin
                    hits = 0;
                    for (int i = 0; i < 4; i++)
                        if (mat[i] && m_mask[k][i]) hits++;
                    if (hits >= m_rem[k]) begin
                        m_state[k] = 2;
                        m_rem[k]   = 0;
                    end else begin
                        m_rem[k] = m_rem[k] - hits;
                    end
                end
            end
            for (int i = 0; i < 4; i++) m_prev[i] = int'(sig_in[i]);
        end
    endtask

    task automatic compare();
        logic [3:0]  ep, es_a, es_b, et_a, et_b;
        logic [31:0] ec_a;
        logic [7:0]  ec_b;
        for (int i = 0; i < 4; i++) begin
            ep[i]           = (m_pulse[i] != 0);
            es_a[i]         = (m_stk[0][i] != 0);
            es_b[i]         = (m_stk[1][i] != 0);
            et_a[i]         = (m_cnt[0][i] == cmax[0]);
            et_b[i]         = (m_cnt[1][i] == cmax[1]);
            ec_a[8*i +: 8]  = 8'(m_cnt[0][i]);
            ec_b[2*i +: 2]  = 2'(m_cnt[1][i]);
        end
        check("pulse_a",  32'(pulse_a),  32'(ep));
        check("count_a",  count_a,       ec_a);
        check("sticky_a", 32'(sticky_a), 32'(es_a));
        check("sat_a",    32'(sat_a),    32'(et_a));
        check("busy_a",   32'(busy_a),   32'(m_state[0] == 1));
        check("done_a",   32'(done_a),   32'(m_state[0] == 2));
        check("pulse_b",  32'(pulse_b),  32'(ep));
        check("count_b",  32'(count_b),  32'(ec_b));
        check("sticky_b", 32'(sticky_b), 32'(es_b));
        check("sat_b",    32'(sat_b),    32'(et_b));
        check("busy_b",   32'(busy_b),   32'(m_state[1] == 1));
        check("done_b",   32'(done_b),   32'(m_state[1] == 2));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_arm(input logic [3:0] msk, input logic [7:0] tgt);
        arm = 1'b1; arm_mask = msk; arm_target = tgt;
        cyc();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; arm = 1'b0; sig_in = 4'hF; mode = 8'hFF;
        arm_mask = '0; arm_target = '0;

        // Reset with inputs high, then hold high: nothing may fire
        cyc(); cyc();
        check("t1_reset_pulse", 32'(pulse_a), 0);
        check("t1_reset_busy",  32'(busy_a),  0);
        rst = 1'b0;
        repeat (3) cyc();
        check("t1_no_pulse",  32'(pulse_a),  0);
        check("t1_count",     count_a,       0);
        check("t1_sticky",    32'(sticky_a), 0);

        // ch0 rise, ch1 any, ch2 off, ch3 fall; sig toggles 1->0->1->0->1
        mode = 8'b10_00_11_01;
        for (int n = 0; n < 4; n++) begin
            sig_in = ~sig_in;
            cyc();
        end
        cyc();
        check("t2_count0", 32'(count_a[7:0]),   2);
        check("t2_count1", 32'(count_a[15:8]),  4);
        check("t2_count2", 32'(count_a[23:16]), 0);
        check("t2_sat1_b", 32'(sat_b[1]),       1);

        // Saturation on the 2-bit instance, then clear, then clear racing an edge
        clear = 1'b1; cyc(); clear = 1'b0;
        mode = 8'h03;
        for (int n = 0; n < 5; n++) begin
            sig_in[0] = ~sig_in[0];
            cyc();
        end
        check("t3_count0_b", 32'(count_b[1:0]), 3);
        check("t3_sat0_b",   32'(sat_b[0]),     1);
        check("t3_count0_a", 32'(count_a[7:0]), 5);
        clear = 1'b1; cyc();
        check("t3_clr_count", 32'(count_b[1:0]), 0);
        check("t3_clr_sat",   32'(sat_b[0]),     0);
        sig_in[0] = ~sig_in[0]; cyc(); clear = 1'b0;
        check("t3_clr_edge_pulse", 32'(pulse_b[0]),   1);
        check("t3_clr_edge_count", 32'(count_b[1:0]), 0);

        // Waiter: mask 0011, target 3
        mode = 8'hFF; sig_in = 4'b0000; cyc();
        sig_in = 4'b0001;
        do_arm(4'b0011, 8'd3);
        check("t4_busy_armed", 32'(busy_a), 1);
        sig_in = 4'b0010; cyc();
        check("t4_busy_2hits", 32'(busy_a), 1);
        sig_in = 4'b0110; cyc();
        check("t4_ch2_ignored", 32'(done_a), 0);
        sig_in = 4'b0111; cyc();
        check("t4_done", 32'(done_a), 1);
        check("t4_busy_off", 32'(busy_a), 0);
        cyc();
        check("t4_done_held", 32'(done_a), 1);

        // target 0, re-arm mid-WAIT, reset mid-WAIT
        do_arm(4'b0001, 8'd0);
        check("t5_done_t0", 32'(done_a), 1);
        do_arm(4'b0001, 8'd5);
        sig_in[0] = ~sig_in[0]; cyc();
        do_arm(4'b0001, 8'd2);
        sig_in[0] = ~sig_in[0]; cyc();
        check("t5_rearm_busy", 32'(busy_a), 1);
        sig_in[0] = ~sig_in[0]; cyc();
        check("t5_rearm_done", 32'(done_a), 1);
        do_arm(4'b0001, 8'd7);
        sig_in[0] = ~sig_in[0]; cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        check("t5_rst_busy",  32'(busy_a),  0);
        check("t5_rst_done",  32'(done_a),  0);
        check("t5_rst_count", count_a,      0);

        // Randomized phase
        for (int n = 0; n < 1500; n++) begin
            sig_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            clear      = ($urandom_range(0, 31) == 0);
            arm        = ($urandom_range(0, 19) == 0);
            arm_mask   = 4'($urandom);
            arm_target = 8'($urandom_range(0, 9));
            rst        = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; clear = 1'b0; arm = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
